// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA prime-search slice.
//   state_t    : prime_search FSM states
//   TAPS_*     : Galois LFSR tap masks for the supported word widths
//   lfsr_taps  : selects the tap mask for a given width (16, 32 or 64)
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_RST_MR,
    S_EN_MR,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  // Tap mask for a right-shifting Galois LFSR of the given width.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      16:      return TAPS_16;
      64:      return TAPS_64;
      default: return TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR with synchronous seed load.
//   clk, rst_n : clock, async active-low reset (state resets to 1)
//   load       : load seed (a zero seed is mapped to 1)
//   step       : advance one step; with load, steps from the new seed
//   seed       : seed value
//   next_c     : combinational next value (step of current or loaded state)
module galois_lfsr
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] next_c
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] base;

  // Load takes effect before the step so a same-cycle step uses the new seed.
  always_comb begin
    base = lfsr_q;
    if (load) base = (seed == '0) ? WIDTH'(1) : seed;
    next_c = base[0] ? ((base >> 1) ^ TAPS) : (base >> 1);
    lfsr_d = lfsr_q;
    if (step)      lfsr_d = next_c;
    else if (load) lfsr_d = base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= WIDTH'(1);
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/prime_search.sv
// Initiator-side driver for the miller_rabin tester: draws odd, MSB-set
// candidates from a Galois LFSR and tests them until one is a probable prime
// or the try budget is spent.
// Optional watchdog per test is built when MR_TIMEOUT_EN is defined.
//   start/seed_load/seed/t_in : search request, LFSR seeding, iteration count
//   busy/done/found/prime/tries : search status and result (registered)
//   timeout                   : watchdog fired (MR_TIMEOUT_EN only)
//   mr_rst/mr_enable/mr_n/mr_t : tester control (registered)
//   mr_done/mr_is_prime       : tester response
module prime_search
  import rsa_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned MAX_TRIES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              seed_load,
  input  logic [WORD_WIDTH-1:0]             seed,
  input  logic [5:0]                        t_in,
  output logic                              busy,
  output logic                              done,
  output logic                              found,
  output logic [WORD_WIDTH-1:0]             prime,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries,
`ifdef MR_TIMEOUT_EN
  output logic                              timeout,
`endif
  output logic                              mr_rst,
  output logic                              mr_enable,
  output logic [WORD_WIDTH-1:0]             mr_n,
  output logic [5:0]                        mr_t,
  input  logic                              mr_done,
  input  logic                              mr_is_prime
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  localparam logic [WORD_WIDTH-1:0] CAND_MASK = {1'b1, (WORD_WIDTH-2)'(0), 1'b1};

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    found_q, found_d;
  logic [WORD_WIDTH-1:0]   prime_q, prime_d;
  logic [TRIES_W-1:0]      tries_q, tries_d;
  logic                    mr_rst_q, mr_rst_d;
  logic                    mr_enable_q, mr_enable_d;
  logic [WORD_WIDTH-1:0]   mr_n_q, mr_n_d;
  logic [5:0]              mr_t_q, mr_t_d;
  logic                    lfsr_load, lfsr_step;
  logic [WORD_WIDTH-1:0]   lfsr_next;

`ifdef MR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic                    timeout_q, timeout_d;
  logic [WD_W-1:0]         wd_q, wd_d;
`endif

  galois_lfsr #(.WIDTH(WORD_WIDTH)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lfsr_load),
    .step   (lfsr_step),
    .seed   (seed),
    .next_c (lfsr_next)
  );

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    found_d   = found_q;
    prime_d   = prime_q;
    tries_d   = tries_q;
    mr_n_d    = mr_n_q;
    mr_t_d    = mr_t_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`ifdef MR_TIMEOUT_EN
    timeout_d = timeout_q;
    wd_d      = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          mr_t_d  = t_in;
          tries_d = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
`ifdef MR_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        lfsr_step = 1'b1;
        mr_n_d    = lfsr_next | CAND_MASK;
        tries_d   = tries_q + TRIES_W'(1);
        state_d   = S_RST_MR;
      end
      S_RST_MR: state_d = S_EN_MR;
      S_EN_MR: begin
`ifdef MR_TIMEOUT_EN
        wd_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mr_done) begin
          if (mr_is_prime) begin
            prime_d = mr_n_q;
            found_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (tries_q == TRIES_W'(MAX_TRIES)) begin
            prime_d = mr_n_q;
            found_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_GEN;
          end
        end
`ifdef MR_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          found_d   = 1'b0;
          prime_d   = mr_n_q;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Tester controls are decoded from the state being entered so they line up with it.
    mr_rst_d    = (state_d == S_IDLE) || (state_d == S_RST_MR);
    mr_enable_d = (state_d == S_EN_MR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      prime_q     <= '0;
      tries_q     <= '0;
      mr_rst_q    <= 1'b1;
      mr_enable_q <= 1'b0;
      mr_n_q      <= '0;
      mr_t_q      <= '0;
`ifdef MR_TIMEOUT_EN
      timeout_q   <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      prime_q     <= prime_d;
      tries_q     <= tries_d;
      mr_rst_q    <= mr_rst_d;
      mr_enable_q <= mr_enable_d;
      mr_n_q      <= mr_n_d;
      mr_t_q      <= mr_t_d;
`ifdef MR_TIMEOUT_EN
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign prime     = prime_q;
  assign tries     = tries_q;
  assign mr_rst    = mr_rst_q;
  assign mr_enable = mr_enable_q;
  assign mr_n      = mr_n_q;
  assign mr_t      = mr_t_q;
`ifdef MR_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule
